// File: rtl/player_pkg.sv
// Shared definitions for the climber sprite motion control: state encoding,
// default geometry and small arithmetic helpers.
package player_pkg;

   typedef enum logic [1:0] {
      GROUND = 2'd0,
      RISE   = 2'd1,
      FALL   = 2'd2,
      RIDE   = 2'd3
   } state_t;

   localparam logic [9:0] PLAYER_H_DEF    = 10'd40;
   localparam logic [9:0] FLOOR_Y_DEF     = 10'd440;
   localparam logic [9:0] JUMP_HEIGHT_DEF = 10'd80;

   function automatic logic [9:0] sat_sub(input logic [9:0] a, input logic [9:0] b);
      return (a > b) ? (a - b) : 10'd0;
   endfunction

endpackage

// File: rtl/motion_tick_div.sv
// Free-running divider producing a one-cycle motion tick every DIV clocks.
module motion_tick_div #(
   parameter int unsigned DIV = 420000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [W-1:0] cnt;

   assign tick = (cnt == W'(DIV - 1));

   always_ff @(posedge clk) begin
      if (rst)       cnt <= '0;
      else if (tick) cnt <= '0;
      else           cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/player_vertical_ctrl.sv
// Vertical motion of the climber: stand, rise, fall, and ride the scrolling
// platform. All outputs come straight from flops.
module player_vertical_ctrl
   import player_pkg::*;
#(
   parameter int unsigned TICK_DIV    = 420000,
   parameter logic [9:0]  JUMP_HEIGHT = JUMP_HEIGHT_DEF,
   parameter logic [9:0]  PLAYER_H    = PLAYER_H_DEF,
   parameter logic [9:0]  FLOOR_Y     = FLOOR_Y_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       jump_btn,
   input  logic [9:0] plataform_start,
   input  logic [9:0] plataform_end,
   output logic [9:0] player_y,
   output logic [1:0] player_state,
   output logic       on_platform
);

   localparam logic [9:0] REST_Y = FLOOR_Y - PLAYER_H;

   state_t      state;
   logic        tick;
   logic        btn_q;
   logic        jump_latch;
   logic [9:0]  apex;
   logic [9:0]  prev_start;

   logic [10:0] feet, feet_n;
   logic        solid, wrap, land, floor_hit, jump_edge;
   logic [9:0]  apex_nxt, ride_y;

   motion_tick_div #(.DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign feet      = {1'b0, player_y} + {1'b0, PLAYER_H};
   assign feet_n    = feet + 11'd1;
   assign solid     = (plataform_start >= PLAYER_H) && (plataform_end <= FLOOR_Y);
   assign wrap      = (plataform_start < prev_start);
   assign land      = solid && ({1'b0, plataform_start} > feet) && ({1'b0, plataform_start} <= feet_n);
   assign floor_hit = (feet_n >= {1'b0, FLOOR_Y});
   assign jump_edge = jump_btn & ~btn_q;
   assign apex_nxt  = sat_sub(player_y, JUMP_HEIGHT);
   assign ride_y    = plataform_start - PLAYER_H;

   assign player_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= GROUND;
         player_y    <= REST_Y;
         on_platform <= 1'b0;
         btn_q       <= 1'b0;
         jump_latch  <= 1'b0;
         apex        <= '0;
         prev_start  <= '0;
      end else begin
         btn_q      <= jump_btn;
         prev_start <= plataform_start;

         // Airborne presses are dropped rather than buffered for the landing.
         if (state == RISE || state == FALL) jump_latch <= 1'b0;
         else if (jump_edge)                 jump_latch <= 1'b1;

         case (state)
            GROUND: begin
               if (tick && jump_latch) begin
                  state      <= RISE;
                  apex       <= apex_nxt;
                  jump_latch <= 1'b0;
               end
            end
            RISE: begin
               if (tick) begin
                  // Guard keeps a zero-height apex from underflowing the row.
                  if (player_y <= apex) begin
                     state <= FALL;
                  end else begin
                     player_y <= player_y - 10'd1;
                     if (player_y - 10'd1 == apex) state <= FALL;
                  end
               end
            end
            FALL: begin
               if (tick) begin
                  if (land) begin
                     player_y    <= ride_y;
                     state       <= RIDE;
                     on_platform <= 1'b1;
                  end else if (floor_hit) begin
                     player_y <= REST_Y;
                     state    <= GROUND;
                  end else begin
                     player_y <= player_y + 10'd1;
                  end
               end
            end
            RIDE: begin
               if (wrap || !solid) begin
                  state       <= FALL;
                  on_platform <= 1'b0;
               end else begin
                  player_y <= ride_y;
                  if (tick && jump_latch) begin
                     state       <= RISE;
                     apex        <= apex_nxt;
                     on_platform <= 1'b0;
                     jump_latch  <= 1'b0;
                  end
               end
            end
            default: state <= GROUND;
         endcase
      end
   end

endmodule
